// File: rtl/window_stream.sv
// window_stream: two-stage streaming window multiplier. It holds a programmable coefficient table,
// uses a valid/ready handshake on both sides and marks the last sample of each frame.
module window_stream #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int FRAME_LEN = 128,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic [COEF_W-1:0] cfg_data,
    output logic              cfg_busy,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam logic signed [PROD_W-1:0] ROUND_HALF = {{(PROD_W-1){1'b0}}, 1'b1} << (COEF_W - 1);

    typedef enum logic [1:0] {
        WIN_RECT = 2'd0,
        WIN_FULL = 2'd1,
        WIN_SYM  = 2'd2
    } win_mode_t;

    win_mode_t                mode_in_s;
    win_mode_t                frame_mode_r;
    win_mode_t                eff_mode_s;
    logic                     adv_s;
    logic                     accept_s;
    logic                     first_s;
    logic                     cfg_wr_s;
    logic [IDX_W-1:0]         idx_r;
    logic [IDX_W-1:0]         tab_addr_s;
    logic [COEF_W-1:0]        coef_tab_r [FRAME_LEN];
    logic                     s1_valid_r;
    logic                     s1_last_r;
    logic                     s1_bypass_r;
    logic signed [DATA_W-1:0] s1_data_r;
    logic [COEF_W-1:0]        s1_coef_r;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [PROD_W-1:0] rnd_s;
    logic                     unused_rnd_bits_s;

    assign adv_s    = !m_valid || m_ready;
    assign s_ready  = adv_s;
    assign accept_s = s_valid && adv_s;
    assign first_s  = (idx_r == {IDX_W{1'b0}});
    // An index-0 sample arriving with a write wins; the write is dropped.
    assign cfg_wr_s = cfg_we && !cfg_busy && !accept_s;

    // Mode decode and table address; ~idx equals FRAME_LEN-1-idx because FRAME_LEN is a power of two.
    always_comb begin
        case (mode)
            2'd1:    mode_in_s = WIN_FULL;
            2'd2:    mode_in_s = WIN_SYM;
            default: mode_in_s = WIN_RECT;
        endcase
        if (first_s) begin
            eff_mode_s = mode_in_s;
        end else begin
            eff_mode_s = frame_mode_r;
        end
        if ((eff_mode_s == WIN_SYM) && idx_r[IDX_W-1]) begin
            tab_addr_s = ~idx_r;
        end else begin
            tab_addr_s = idx_r;
        end
    end

    // Signed sample times zero-extended coefficient, rounded half toward +inf.
    always_comb begin
        prod_s            = PROD_W'(s1_data_r) * PROD_W'($signed({1'b0, s1_coef_r}));
        rnd_s             = prod_s + ROUND_HALF;
        unused_rnd_bits_s = ^{rnd_s[PROD_W-1], rnd_s[COEF_W-1:0]};
    end

    // Coefficient table: cleared by reset, writable only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                coef_tab_r[i] <= {COEF_W{1'b0}};
            end
        end else if (cfg_wr_s) begin
            coef_tab_r[cfg_addr] <= cfg_data;
        end
    end

    // Frame index, per-frame mode latch and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r        <= {IDX_W{1'b0}};
            frame_mode_r <= WIN_RECT;
            cfg_busy     <= 1'b0;
        end else begin
            if (accept_s) begin
                idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                if (first_s) begin
                    frame_mode_r <= mode_in_s;
                end
            end
            if (accept_s && first_s) begin
                cfg_busy <= 1'b1;
            end else if (first_s && !s1_valid_r && !m_valid) begin
                cfg_busy <= 1'b0;
            end
        end
    end

    // Both stages move together whenever the output slot is free or being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_last_r   <= 1'b0;
            s1_bypass_r <= 1'b0;
            s1_data_r   <= {DATA_W{1'b0}};
            s1_coef_r   <= {COEF_W{1'b0}};
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            m_data      <= {DATA_W{1'b0}};
        end else if (adv_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_data_r   <= $signed(s_data);
                s1_coef_r   <= coef_tab_r[tab_addr_s];
                s1_last_r   <= &idx_r;
                s1_bypass_r <= (eff_mode_s == WIN_RECT);
            end
            m_valid <= s1_valid_r;
            m_last  <= s1_valid_r && s1_last_r;
            if (s1_valid_r) begin
                if (s1_bypass_r) begin
                    m_data <= s1_data_r;
                end else begin
                    m_data <= rnd_s[COEF_W +: DATA_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_window_stream.sv
// Self-checking bench for window_stream: randomized frames against a scoreboard of expected outputs
// computed from the windowing rules (FRAME_LEN=8), plus a FRAME_LEN=128 symmetric-table instance.
module tb_window_stream;
    localparam int FL = 8;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_busy, s_valid, s_ready, m_valid, m_ready, m_last;
    logic [7:0] s_data, m_data;

    logic [1:0] b_mode;
    logic       b_cfg_we;
    logic [6:0] b_cfg_addr;
    logic [7:0] b_cfg_data;
    logic       b_cfg_busy, b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_m_last;
    logic [7:0] b_s_data, b_m_data;

    int n_vec = 0;
    int n_err = 0;

    int   mtab [FL];
    int   m_idx;
    int   m_mode;
    exp_t exp_q[$];
    exp_t exp_cur;
    logic have_exp, hs_in, hs_out;
    logic obs_sready, obs_valid, obs_last, obs_busy;
    logic [7:0] obs_data;

    window_stream #(.DATA_W(8), .COEF_W(8), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_busy(cfg_busy), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    window_stream #(.DATA_W(8), .COEF_W(8), .FRAME_LEN(128)) dut128 (
        .clk(clk), .rst_n(rst_n), .mode(b_mode), .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr),
        .cfg_data(b_cfg_data), .cfg_busy(b_cfg_busy), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .s_data(b_s_data), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .m_last(b_m_last)
    );

    always #5 clk = ~clk;

    // Windowed value of one sample: round(s * c / 256) with ties toward +inf.
    function automatic int win_value(input int s, input int c);
        return $rtoi($floor(real'(s * c) / 256.0 + 0.5));
    endfunction

    // Reference for one accepted sample; updates the frame position and latched mode.
    function automatic exp_t model_accept(input int s, input logic [1:0] md);
        exp_t e;
        int   k;
        int   y;
        if (m_idx == 0) m_mode = (md == 2'd3) ? 0 : int'(md);
        k = (m_mode == 2 && m_idx >= FL / 2) ? FL - 1 - m_idx : m_idx;
        y = (m_mode == 0) ? s : win_value(s, mtab[k]);
        e.d = y[7:0];
        e.l = (m_idx == FL - 1);
        m_idx = (m_idx + 1) % FL;
        return e;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < FL; k++) mtab[k] = 0;
        m_idx  = 0;
        m_mode = 0;
        exp_q.delete();
    endfunction

    // One clock of stream traffic: observe at the falling edge, update the scoreboard, pass the rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic [1:0] md);
        s_valid = v; s_data = d; m_ready = r; mode = md;
        @(negedge clk);
        obs_sready = s_ready; obs_valid = m_valid; obs_data = m_data;
        obs_last = m_last; obs_busy = cfg_busy;
        hs_in  = v && s_ready;
        hs_out = m_valid && r;
        have_exp = 1'b0;
        if (hs_out && exp_q.size() > 0) begin
            exp_cur  = exp_q.pop_front();
            have_exp = 1'b1;
        end
        if (hs_in) exp_q.push_back(model_accept(int'($signed(d)), md));
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int a, input int c);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_data = 8'(c);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic load_random_table(input int lo, input int hi);
        int c;
        for (int k = 0; k < FL; k++) begin
            c = int'($urandom_range(hi, lo));
            cfg_write(k, c);
            mtab[k] = c;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        n_vec++; if (m_data !== 8'd0) begin n_err++; $display("FAIL reset_m_data: got %0d expected 0", m_data); end
        n_vec++; if (m_last !== 1'b0) begin n_err++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
        n_vec++; if (cfg_busy !== 1'b0) begin n_err++; $display("FAIL reset_cfg_busy: got %b expected 0", cfg_busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        model_reset();
    endtask

    task automatic test_len128();
        int j, kk, c, e;
        b_cfg_we = 1'b1; b_cfg_addr = 7'd0; b_cfg_data = 8'd64;
        @(posedge clk); #1;
        b_cfg_addr = 7'd63; b_cfg_data = 8'd192;
        @(posedge clk); #1;
        b_cfg_we = 1'b0; b_mode = 2'd2; b_m_ready = 1'b1; b_s_data = 8'd100;
        j = 0;
        for (int i = 0; i < 140; i++) begin
            b_s_valid = (i < 128);
            @(negedge clk);
            if (b_m_valid && b_m_ready) begin
                kk = (j < 64) ? j : 127 - j;
                c  = (kk == 0) ? 64 : ((kk == 63) ? 192 : 0);
                e  = win_value(100, c);
                n_vec++;
                if (b_m_data !== 8'(e) || b_m_last !== (j == 127)) begin
                    n_err++;
                    $display("FAIL len128_out[%0d]: got %0d/%b expected %0d/%b", j, b_m_data, b_m_last, e, j == 127);
                end
                j++;
            end
            @(posedge clk); #1;
        end
        b_s_valid = 1'b0;
        n_vec++; if (j != 128) begin n_err++; $display("FAIL len128_count: got %0d expected 128", j); end
    endtask

    task automatic test_rect();
        int first_acc, first_val, n_acc;
        logic [7:0] d;
        first_acc = -1; first_val = -1; n_acc = 0;
        for (int i = 0; i < 22; i++) begin
            d = (i < 8) ? 8'd2 : 8'($urandom);
            step(i < 16, d, 1'b1, (i < 8) ? 2'd0 : 2'd3);
            if (hs_in) begin n_acc++; if (first_acc < 0) first_acc = i; end
            if (obs_valid && first_val < 0) first_val = i;
            if (hs_out) begin
                n_vec++;
                if (!have_exp || obs_data !== exp_cur.d || obs_last !== exp_cur.l) begin
                    n_err++;
                    $display("FAIL rect_out: got %0d/%b expected %0d/%b", obs_data, obs_last, exp_cur.d, exp_cur.l);
                end
            end
        end
        n_vec++; if (first_val - first_acc != 2) begin n_err++; $display("FAIL rect_latency: got %0d expected 2", first_val - first_acc); end
        n_vec++; if (n_acc != 16) begin n_err++; $display("FAIL rect_no_bubble: got %0d expected 16", n_acc); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rect_drain: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_rounding();
        int smp[8];
        int spec_exp[5];
        int j;
        smp = '{2, 3, -3, 127, -128, 0, 0, 0};
        spec_exp = '{1, 2, -1, 64, -64};
        for (int k = 5; k < 8; k++) smp[k] = int'($signed(8'($urandom)));
        n_vec++; if (cfg_busy !== 1'b0) begin n_err++; $display("FAIL round_idle: got %b expected 0", cfg_busy); end
        for (int k = 0; k < FL; k++) begin cfg_write(k, 128); mtab[k] = 128; end
        j = 0;
        for (int i = 0; i < 14; i++) begin
            step(i < 8, (i < 8) ? 8'(smp[i]) : 8'd0, 1'b1, 2'd1);
            if (hs_out) begin
                n_vec++;
                if (!have_exp || obs_data !== exp_cur.d || obs_last !== exp_cur.l) begin
                    n_err++;
                    $display("FAIL round_out: got %0d/%b expected %0d/%b", obs_data, obs_last, exp_cur.d, exp_cur.l);
                end
                if (j < 5) begin
                    n_vec++;
                    if ($signed(obs_data) !== 8'(spec_exp[j])) begin
                        n_err++;
                        $display("FAIL round_spec[%0d]: got %0d expected %0d", j, $signed(obs_data), spec_exp[j]);
                    end
                end
                j++;
            end
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL round_drain: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_symmetric();
        int cs[4];
        int sym_exp[8];
        int j;
        logic [1:0] md;
        cs = '{32, 64, 128, 255};
        sym_exp = '{13, 25, 50, 100, 100, 50, 25, 13};
        n_vec++; if (cfg_busy !== 1'b0) begin n_err++; $display("FAIL sym_idle: got %b expected 0", cfg_busy); end
        for (int k = 0; k < FL; k++) begin
            mtab[k] = (k < 4) ? cs[k] : 7;
            cfg_write(k, mtab[k]);
        end
        j = 0;
        for (int i = 0; i < 30; i++) begin
            md = (i < 11) ? 2'd2 : 2'd1;
            step(i < 24, (i < 8) ? 8'd100 : 8'($urandom), 1'b1, md);
            if (hs_out) begin
                n_vec++;
                if (!have_exp || obs_data !== exp_cur.d || obs_last !== exp_cur.l) begin
                    n_err++;
                    $display("FAIL sym_out: got %0d/%b expected %0d/%b", obs_data, obs_last, exp_cur.d, exp_cur.l);
                end
                if (j < 8) begin
                    n_vec++;
                    if (obs_data !== 8'(sym_exp[j])) begin
                        n_err++;
                        $display("FAIL sym_spec[%0d]: got %0d expected %0d", j, obs_data, sym_exp[j]);
                    end
                end
                j++;
            end
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sym_drain: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        logic r, prev_stall, prev_last;
        logic [7:0] prev_data;
        int sent;
        pat = 4'b1001;
        prev_stall = 1'b0; prev_last = 1'b0; prev_data = 8'd0; sent = 0;
        n_vec++; if (cfg_busy !== 1'b0) begin n_err++; $display("FAIL bp_idle: got %b expected 0", cfg_busy); end
        load_random_table(0, 255);
        for (int i = 0; i < 60; i++) begin
            r = (i >= 50) ? 1'b1 : ((i < 24) ? pat[i % 4] : 1'($urandom));
            step(sent < 16, 8'($urandom), r, 2'd1);
            if (hs_in) sent++;
            if (prev_stall) begin
                n_vec++;
                if (obs_valid !== 1'b1 || obs_data !== prev_data || obs_last !== prev_last) begin
                    n_err++;
                    $display("FAIL bp_hold: got %b/%0d/%b expected 1/%0d/%b", obs_valid, obs_data, obs_last, prev_data, prev_last);
                end
            end
            if (obs_valid && !r) begin
                n_vec++;
                if (obs_sready !== 1'b0) begin n_err++; $display("FAIL bp_s_ready: got %b expected 0", obs_sready); end
            end
            if (hs_out) begin
                n_vec++;
                if (!have_exp || obs_data !== exp_cur.d || obs_last !== exp_cur.l) begin
                    n_err++;
                    $display("FAIL bp_out: got %0d/%b expected %0d/%b", obs_data, obs_last, exp_cur.d, exp_cur.l);
                end
            end
            prev_stall = obs_valid && !r;
            prev_data  = obs_data;
            prev_last  = obs_last;
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_drain: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_lockout();
        int j;
        n_vec++; if (cfg_busy !== 1'b0) begin n_err++; $display("FAIL lock_idle: got %b expected 0", cfg_busy); end
        load_random_table(16, 255);
        for (int f = 0; f < 3; f++) begin
            if (f == 2) begin
                n_vec++; if (cfg_busy !== 1'b0) begin n_err++; $display("FAIL lock_drained: got %b expected 0", cfg_busy); end
                cfg_write(2, 0);
                mtab[2] = 0;
            end
            j = 0;
            for (int i = 0; i < 14; i++) begin
                cfg_we   = (f == 0 && i == 3) || (f == 1 && i == 0);
                cfg_addr = (f == 0) ? 3'd2 : 3'd5;
                cfg_data = 8'd0;
                step(i < 8, 8'($urandom_range(127, 64)), 1'b1, 2'd1);
                cfg_we = 1'b0;
                if (f == 0 && i == 3) begin
                    n_vec++; if (obs_busy !== 1'b1) begin n_err++; $display("FAIL lock_busy: got %b expected 1", obs_busy); end
                end
                if (hs_out) begin
                    n_vec++;
                    if (!have_exp || obs_data !== exp_cur.d || obs_last !== exp_cur.l) begin
                        n_err++;
                        $display("FAIL lock_out[f%0d]: got %0d/%b expected %0d/%b", f, obs_data, obs_last, exp_cur.d, exp_cur.l);
                    end
                    if (f == 2 && j == 2) begin
                        n_vec++; if (obs_data !== 8'd0) begin n_err++; $display("FAIL lock_new_coef: got %0d expected 0", obs_data); end
                    end
                    j++;
                end
            end
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL lock_drain: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_midframe();
        load_random_table(16, 255);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'($urandom_range(127, 64)), 1'b1, 2'd1);
            if (hs_out) begin
                n_vec++;
                if (!have_exp || obs_data !== exp_cur.d || obs_last !== exp_cur.l) begin
                    n_err++;
                    $display("FAIL rstmid_pre: got %0d/%b expected %0d/%b", obs_data, obs_last, exp_cur.d, exp_cur.l);
                end
            end
        end
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_m_valid: got %b expected 0", m_valid); end
        n_vec++; if (m_data !== 8'd0) begin n_err++; $display("FAIL rstmid_m_data: got %0d expected 0", m_data); end
        n_vec++; if (cfg_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", cfg_busy); end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 14; i++) begin
            step(i < 8, 8'($urandom_range(127, 64)), 1'b1, 2'd1);
            if (hs_out) begin
                n_vec++;
                if (!have_exp || obs_data !== exp_cur.d || obs_last !== exp_cur.l || obs_data !== 8'd0) begin
                    n_err++;
                    $display("FAIL rstmid_post: got %0d/%b expected %0d/%b", obs_data, obs_last, exp_cur.d, exp_cur.l);
                end
            end
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rstmid_drain: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        mode = 2'd0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 8'd0;
        s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b1;
        b_mode = 2'd0; b_cfg_we = 1'b0; b_cfg_addr = 7'd0; b_cfg_data = 8'd0;
        b_s_valid = 1'b0; b_s_data = 8'd0; b_m_ready = 1'b1;
        model_reset();
        test_reset();
        test_len128();
        test_rect();
        test_rounding();
        test_symmetric();
        test_backpressure();
        test_lockout();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
